// File: rtl/rocket_controller.sv
`timescale 1ns/1ps
// Single-rocket sequencer: launch from the tank, per-frame flight, explosion hold, cooldown.
// Produces the rocket's top-left position and status flags for the VGA object layer.
module rocket_controller #(
    parameter int unsigned SPEED           = 4,
    parameter int unsigned ROCKET_W        = 8,
    parameter int unsigned ROCKET_H        = 8,
    parameter int unsigned TANK_SIZE       = 32,
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned SCREEN_H        = 480,
    parameter int unsigned EXPLODE_FRAMES  = 8,
    parameter int unsigned COOLDOWN_FRAMES = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        fire,
    input  logic [10:0] tankX,
    input  logic [10:0] tankY,
    input  logic [1:0]  tankDir,
    input  logic        collision,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        rocketActive,
    output logic        exploding,
    output logic        fireAck
);

    localparam int unsigned CNT_W = 8;
    localparam logic signed [11:0] OFS_X = 12'((TANK_SIZE - ROCKET_W) / 2);
    localparam logic signed [11:0] OFS_Y = 12'((TANK_SIZE - ROCKET_H) / 2);
    localparam logic signed [11:0] TS_S  = 12'(TANK_SIZE);
    localparam logic signed [11:0] RW_S  = 12'(ROCKET_W);
    localparam logic signed [11:0] RH_S  = 12'(ROCKET_H);
    localparam logic [CNT_W-1:0] EXP_LAST  = CNT_W'(EXPLODE_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FLYING, S_EXPLODE, S_COOLDOWN} state_t;

    state_t             state, state_nxt;
    logic [1:0]         dir, dir_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [10:0]        x_nxt, y_nxt;
    logic               active_nxt, explode_nxt, ack_nxt;
    logic signed [11:0] tank_x_s, tank_y_s, spawn_x_c, spawn_y_c;
    logic               spawn_ok_c, exit_c;

    // Spawn point next to the tank, in signed arithmetic so off-screen-left/top is detectable
    always_comb begin
        tank_x_s = signed'({1'b0, tankX});
        tank_y_s = signed'({1'b0, tankY});
        case (tankDir)
            2'd0:    begin spawn_x_c = tank_x_s + OFS_X; spawn_y_c = tank_y_s - RH_S;  end
            2'd1:    begin spawn_x_c = tank_x_s + TS_S;  spawn_y_c = tank_y_s + OFS_Y; end
            2'd2:    begin spawn_x_c = tank_x_s + OFS_X; spawn_y_c = tank_y_s + TS_S;  end
            default: begin spawn_x_c = tank_x_s - RW_S;  spawn_y_c = tank_y_s + OFS_Y; end
        endcase
        spawn_ok_c = !spawn_x_c[11] && !spawn_y_c[11]
                  && (({1'b0, spawn_x_c} + 13'(ROCKET_W)) <= 13'(SCREEN_W))
                  && (({1'b0, spawn_y_c} + 13'(ROCKET_H)) <= 13'(SCREEN_H));
    end

    // Would the next step along the latched heading leave the screen
    always_comb begin
        case (dir)
            2'd0:    exit_c = topLeftY < 11'(SPEED);
            2'd1:    exit_c = (12'(topLeftX) + 12'(SPEED + ROCKET_W)) > 12'(SCREEN_W);
            2'd2:    exit_c = (12'(topLeftY) + 12'(SPEED + ROCKET_H)) > 12'(SCREEN_H);
            default: exit_c = topLeftX < 11'(SPEED);
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        x_nxt     = topLeftX;
        y_nxt     = topLeftY;
        ack_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fire && spawn_ok_c) begin
                    state_nxt = S_FLYING;
                    dir_nxt   = tankDir;
                    x_nxt     = spawn_x_c[10:0];
                    y_nxt     = spawn_y_c[10:0];
                    ack_nxt   = 1'b1;
                end
            end
            S_FLYING: begin
                if (collision) begin
                    state_nxt = S_EXPLODE;
                end else if (startOfFrame) begin
                    if (exit_c) begin
                        state_nxt = S_COOLDOWN;
                    end else begin
                        case (dir)
                            2'd0:    y_nxt = topLeftY - 11'(SPEED);
                            2'd1:    x_nxt = topLeftX + 11'(SPEED);
                            2'd2:    y_nxt = topLeftY + 11'(SPEED);
                            default: x_nxt = topLeftX - 11'(SPEED);
                        endcase
                    end
                end
            end
            S_EXPLODE: begin
                if (startOfFrame) begin
                    if (cnt == EXP_LAST) state_nxt = S_COOLDOWN;
                    else                 cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            S_COOLDOWN: begin
                if (startOfFrame) begin
                    if (cnt == COOL_LAST) state_nxt = S_IDLE;
                    else                  cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
        active_nxt  = (state_nxt == S_FLYING);
        explode_nxt = (state_nxt == S_EXPLODE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= S_IDLE;
            dir          <= 2'd0;
            cnt          <= '0;
            topLeftX     <= 11'd0;
            topLeftY     <= 11'd0;
            rocketActive <= 1'b0;
            exploding    <= 1'b0;
            fireAck      <= 1'b0;
        end else begin
            state        <= state_nxt;
            dir          <= dir_nxt;
            cnt          <= cnt_nxt;
            topLeftX     <= x_nxt;
            topLeftY     <= y_nxt;
            rocketActive <= active_nxt;
            exploding    <= explode_nxt;
            fireAck      <= ack_nxt;
        end
    end

endmodule

// File: tb/tb_rocket_controller.sv
`timescale 1ns/1ps
// Directed bench for rocket_controller: launches, edge exits, collision race, reset abort.
module tb_rocket_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        fire;
    logic [10:0] tankX;
    logic [10:0] tankY;
    logic [1:0]  tankDir;
    logic        collision;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        rocketActive;
    logic        exploding;
    logic        fireAck;

    int n_tests = 0;
    int n_fail  = 0;

    rocket_controller dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .fire         (fire),
        .tankX        (tankX),
        .tankY        (tankY),
        .tankDir      (tankDir),
        .collision    (collision),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .rocketActive (rocketActive),
        .exploding    (exploding),
        .fireAck      (fireAck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic do_reset();
        fire = 1'b0; startOfFrame = 1'b0; collision = 1'b0;
        resetN = 1'b0;
        step();
        step();
        resetN = 1'b1;
        step();
    endtask

    task automatic launch(input int tx, input int ty, input int td);
        tankX = 11'(tx); tankY = 11'(ty); tankDir = 2'(td);
        fire = 1'b1;
        step();
        fire = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; fire = 1'b0; collision = 1'b0;
        tankX = '0; tankY = '0; tankDir = '0;
        #2;
        check("rst_x", topLeftX, 0);
        check("rst_y", topLeftY, 0);
        check("rst_active", rocketActive, 0);
        check("rst_expl", exploding, 0);
        check("rst_ack", fireAck, 0);
        do_reset();

        // Up launch and three frames of flight
        launch(100, 200, 0);
        check("up_ack", fireAck, 1);
        check("up_active", rocketActive, 1);
        check("up_x", topLeftX, 112);
        check("up_y", topLeftY, 192);
        step();
        check("up_ack_pulse", fireAck, 0);
        tankDir = 2'd1;
        for (int i = 0; i < 3; i++) pulse_sof();
        check("up_fly_y", topLeftY, 180);
        check("up_fly_x", topLeftX, 112);
        check("up_fly_active", rocketActive, 1);
        do_reset();

        // Invalid spawn above the screen: no ack for 10 clocks
        tankX = 11'd100; tankY = 11'd4; tankDir = 2'd0; fire = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("inv_ack", fireAck, 0);
        end
        fire = 1'b0;
        check("inv_active", rocketActive, 0);
        check("inv_x", topLeftX, 0);
        check("inv_y", topLeftY, 0);
        // Invalid spawn off the left edge
        tankX = 11'd4; tankY = 11'd200; tankDir = 2'd3; fire = 1'b1;
        step();
        fire = 1'b0;
        check("inv_left_ack", fireAck, 0);

        // Left launch moves X down by SPEED
        launch(100, 200, 3);
        check("left_x", topLeftX, 92);
        check("left_y", topLeftY, 212);
        pulse_sof();
        check("left_fly_x", topLeftX, 88);
        do_reset();

        // Right-edge exit, then cooldown with fire re-asserted late
        launch(600, 100, 1);
        check("re_ack", fireAck, 1);
        check("re_x", topLeftX, 632);
        check("re_y", topLeftY, 112);
        pulse_sof();
        check("re_exit_active", rocketActive, 0);
        check("re_exit_expl", exploding, 0);
        check("re_exit_x", topLeftX, 632);
        for (int i = 0; i < 15; i++) pulse_sof();
        fire = 1'b1;
        step();
        check("re_cool_ack", fireAck, 0);
        pulse_sof();
        check("re_idle_ack", fireAck, 0);
        step();
        check("re_relaunch_ack", fireAck, 1);
        check("re_relaunch_act", rocketActive, 1);
        fire = 1'b0;
        do_reset();

        // Collision and startOfFrame in the same clock
        launch(188, 268, 2);
        check("race_x0", topLeftX, 200);
        check("race_y0", topLeftY, 300);
        collision = 1'b1; startOfFrame = 1'b1;
        step();
        collision = 1'b0; startOfFrame = 1'b0;
        check("race_expl", exploding, 1);
        check("race_active", rocketActive, 0);
        check("race_x", topLeftX, 200);
        check("race_y", topLeftY, 300);
        for (int i = 0; i < 7; i++) pulse_sof();
        check("race_expl7", exploding, 1);
        pulse_sof();
        check("race_expl8", exploding, 0);
        check("race_cool_act", rocketActive, 0);
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("race_cool_coll", exploding, 0);
        do_reset();

        // Fire held through a whole flight, explosion and cooldown
        tankX = 11'd188; tankY = 11'd268; tankDir = 2'd2; fire = 1'b1;
        step();
        check("held_ack1", fireAck, 1);
        step();
        check("held_fly_ack", fireAck, 0);
        tankDir = 2'd0;
        pulse_sof();
        check("held_dir_ignored", topLeftY, 304);
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("held_expl", exploding, 1);
        for (int i = 0; i < 8; i++) begin
            pulse_sof();
            check("held_expl_ack", fireAck, 0);
        end
        check("held_expl_done", exploding, 0);
        for (int i = 0; i < 16; i++) begin
            pulse_sof();
            check("held_cool_ack", fireAck, 0);
        end
        step();
        check("held_ack2", fireAck, 1);
        check("held_x2", topLeftX, 200);
        check("held_y2", topLeftY, 260);
        fire = 1'b0;
        do_reset();

        // Reset mid-flight aborts at once
        launch(288, 118, 2);
        check("mid_x", topLeftX, 300);
        check("mid_y", topLeftY, 150);
        #2;
        resetN = 1'b0;
        #1;
        check("mid_rst_x", topLeftX, 0);
        check("mid_rst_y", topLeftY, 0);
        check("mid_rst_act", rocketActive, 0);
        check("mid_rst_expl", exploding, 0);
        step();
        resetN = 1'b1;
        step();
        launch(100, 200, 0);
        check("mid_relaunch_ack", fireAck, 1);
        check("mid_relaunch_x", topLeftX, 112);
        check("mid_relaunch_y", topLeftY, 192);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rocket_controller.md
Name: rocket_controller

Overview:
Sequences a single tank rocket through launch, flight, explosion and cooldown. It converts a fire request plus the tank position and heading into a per-frame rocket top-left position. That position drives the rocket's square drawing object, which turns it into a drawing request. The controller sits between the player/tank logic and the VGA object layer, and takes collision feedback from the hit-detection block.

Parameters:
SPEED, 4, pixels moved per frame while flying
ROCKET_W, 8, rocket width in pixels (must match the drawing object's width)
ROCKET_H, 8, rocket height in pixels
TANK_SIZE, 32, tank square side in pixels
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
EXPLODE_FRAMES, 8, frames spent in the explosion state (1..255)
COOLDOWN_FRAMES, 16, frames before the next launch is accepted (1..255)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous reset, active low
startOfFrame  in  1  one-clk pulse, once per VGA frame
fire  in  1  launch request, level, sampled every clk
tankX  in  11  tank top-left X
tankY  in  11  tank top-left Y
tankDir  in  2  tank heading: 0=up, 1=right, 2=down, 3=left
collision  in  1  rocket hit something, sampled every clk
topLeftX  out  11  rocket top-left X, to the drawing object
topLeftY  out  11  rocket top-left Y
rocketActive  out  1  1 while flying; gates the rocket's drawing request
exploding  out  1  1 in the EXPLODE state
fireAck  out  1  one-clk pulse when a launch is accepted

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE
  - topLeftX=topLeftY=0
  - latched direction=0, frame counter=0
  - all 1-bit outputs 0
  - Reset mid-flight aborts immediately, with no explosion.
- States: IDLE, FLYING, EXPLODE, COOLDOWN. All transitions are registered.
- IDLE:
  - If fire=1 and the spawn position is on-screen: latch tankDir, load the spawn position, pulse fireAck, and enter FLYING on the next edge.
  - Spawn position by direction:
    - up: X=tankX+(TANK_SIZE-ROCKET_W)/2, Y=tankY-ROCKET_H
    - down: same X, Y=tankY+TANK_SIZE
    - left: X=tankX-ROCKET_W, Y=tankY+(TANK_SIZE-ROCKET_H)/2
    - right: X=tankX+TANK_SIZE, same Y
  - Spawn arithmetic uses 12-bit signed. If the result is <0 or the rocket would exceed SCREEN_W/SCREEN_H, the request is ignored, with no fireAck.
- FLYING:
  - rocketActive=1.
  - collision=1 has priority over everything, including startOfFrame in the same cycle: enter EXPLODE, position frozen.
  - Otherwise, on startOfFrame, test the next position:
    - Leaves the screen (up: Y<SPEED; left: X<SPEED; right: X+SPEED+ROCKET_W>SCREEN_W; down: Y+SPEED+ROCKET_H>SCREEN_H): enter COOLDOWN, position unchanged.
    - Otherwise: add/subtract SPEED on the latched axis.
  - tankDir changes during flight are ignored.
- EXPLODE:
  - exploding=1, rocketActive=0, position held so the explosion sprite can use it.
  - Frame counter counts startOfFrame pulses. After EXPLODE_FRAMES pulses: enter COOLDOWN and clear the counter.
- COOLDOWN:
  - All flags 0; fire is ignored.
  - After COOLDOWN_FRAMES startOfFrame pulses: enter IDLE and clear the counter.
  - If fire is still held, a new launch is accepted on the first IDLE cycle. Auto-repeat is intended.
- The counter clears on every state entry.
- Latency: fire to fireAck is 1 clk. fireAck to rocketActive=1 is the same edge (both registered outputs of the IDLE->FLYING transition).
- collision arriving outside FLYING is ignored.

Test Plan:
- Up launch: tankX=100, tankY=200, tankDir=0, fire 1 clk -> fireAck 1 clk; topLeft=(112,192), rocketActive=1; after 3 startOfFrame pulses topLeftY=180, X unchanged.
- Right-edge exit: tankX=600, tankY=100, tankDir=1, fire -> spawn (632,112); first startOfFrame -> COOLDOWN, rocketActive=0, no exploding; after 16 pulses back to IDLE.
- Collision/frame race: FLYING at (200,300) heading down; collision and startOfFrame in the same clk -> EXPLODE, position stays (200,300); exploding high for exactly 8 pulses, then 16 cooldown pulses.
- Invalid spawn: tankY=4, tankDir=0, fire held 10 clks -> no fireAck, stays IDLE, outputs 0.
- Held fire: fire held through a complete flight and cooldown -> no fireAck during FLYING/EXPLODE/COOLDOWN; second fireAck on the first clk after IDLE re-entry.
- Reset mid-flight: resetN low while FLYING at (300,150) -> outputs immediately 0, state IDLE; after release, fire relaunches normally.
